prescaled_down_counter: RTL and testbench



---
 rtl/prescaled_down_counter.sv | 119 +++++++++++
 tb/tb_prescaled_down_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prescaled_down_counter.sv
// Loadable countdown timer with a built-in prescaler, pause/resume,
// expiry level + pulse, and optional auto-reload of the last loaded value.
module prescaled_down_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PRE_W       = 26,
    parameter int unsigned DIV_COUNT   = 25000000,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] counter,
    output logic             running,
    output logic             done,
    output logic             expire_pulse
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_COUNT - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] counter_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_next;
    logic             expire_next;

    // State and datapath registers; running/done track the next state so they
    // always agree with the state register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            reload_reg   <= '0;
            prescaler    <= '0;
            running      <= 1'b0;
            done         <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            counter      <= counter_next;
            reload_reg   <= reload_next;
            prescaler    <= prescaler_next;
            running      <= (state_next == RUN);
            done         <= (state_next == DONE);
            expire_pulse <= expire_next;
        end
    end

    // Next-state and datapath: load beats start/pause, which beat the tick.
    always_comb begin
        state_next     = state;
        counter_next   = counter;
        reload_next    = reload_reg;
        prescaler_next = prescaler;
        expire_next    = 1'b0;

        if (load) begin
            counter_next   = load_value;
            reload_next    = load_value;
            prescaler_next = '0;
            state_next     = ((state == RUN) && (load_value != '0)) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    prescaler_next = '0;
                    if (start && (counter != '0)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (prescaler == PRE_LAST) begin
                        prescaler_next = '0;
                        if (counter == CNT_ONE) begin
                            expire_next = 1'b1;
                            if (AUTO_RELOAD) begin
                                counter_next = reload_reg;
                            end else begin
                                counter_next = '0;
                                state_next   = DONE;
                            end
                        end else if (counter != '0) begin
                            counter_next = counter - CNT_ONE;
                        end
                    end else begin
                        prescaler_next = prescaler + PRE_W'(1);
                    end
                end
                PAUSE: begin
                    // Prescaler stays frozen so the partial period carries over.
                    if (start) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    counter_next = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prescaled_down_counter.sv
// Directed bench for prescaled_down_counter: a vector table for the basic
// countdown plus hand-written sequences for pause, collisions, reset and reload.
module tb_prescaled_down_counter;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [3];
    logic         ld  [3];
    logic [W-1:0] lv  [3];
    logic         st  [3];
    logic         pz  [3];
    logic [W-1:0] cnt [3];
    logic         run [3];
    logic         dn  [3];
    logic         ep  [3];

    // 0: DIV 4 single-shot, 1: DIV 4 auto-reload, 2: DIV 2 single-shot
    prescaled_down_counter #(.WIDTH(W), .PRE_W(26), .DIV_COUNT(4), .AUTO_RELOAD(1'b0)) dut0 (
        .clk_in(clk), .reset(rst[0]), .load(ld[0]), .load_value(lv[0]), .start(st[0]),
        .pause(pz[0]), .counter(cnt[0]), .running(run[0]), .done(dn[0]), .expire_pulse(ep[0]));
    prescaled_down_counter #(.WIDTH(W), .PRE_W(26), .DIV_COUNT(4), .AUTO_RELOAD(1'b1)) dut1 (
        .clk_in(clk), .reset(rst[1]), .load(ld[1]), .load_value(lv[1]), .start(st[1]),
        .pause(pz[1]), .counter(cnt[1]), .running(run[1]), .done(dn[1]), .expire_pulse(ep[1]));
    prescaled_down_counter #(.WIDTH(W), .PRE_W(26), .DIV_COUNT(2), .AUTO_RELOAD(1'b0)) dut2 (
        .clk_in(clk), .reset(rst[2]), .load(ld[2]), .load_value(lv[2]), .start(st[2]),
        .pause(pz[2]), .counter(cnt[2]), .running(run[2]), .done(dn[2]), .expire_pulse(ep[2]));

    typedef struct {
        logic         l;
        logic [W-1:0] v;
        logic         s;
        logic         p;
        logic [W-1:0] c;
        logic         r;
        logic         d;
        logic         e;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d, input logic l, input logic [W-1:0] v,
                         input logic s, input logic p);
        ld[d] = l;
        lv[d] = v;
        st[d] = s;
        pz[d] = p;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_all(input string tag, input int d, input logic [W-1:0] c,
                             input logic r, input logic dd, input logic e);
        check({tag, ".counter"}, 32'(cnt[d]), 32'(c));
        check({tag, ".running"}, 32'(run[d]), 32'(r));
        check({tag, ".done"}, 32'(dn[d]), 32'(dd));
        check({tag, ".expire"}, 32'(ep[d]), 32'(e));
    endtask

    function automatic void add(input logic l, input logic [W-1:0] v, input logic s,
                                input logic p, input logic [W-1:0] c, input logic r,
                                input logic d, input logic e);
        vec_t t;
        t.l = l; t.v = v; t.s = s; t.p = p;
        t.c = c; t.r = r; t.d = d; t.e = e;
        tbl.push_back(t);
    endfunction

    initial begin
        int found;
        logic [W-1:0] exp_c;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            drive(i, 1'b0, 8'd0, 1'b0, 1'b0);
        end
        step(2);
        for (int i = 0; i < 3; i++) check_all($sformatf("reset%0d", i), i, 8'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Basic single-shot countdown from 3 with DIV 4; start edge is E0
        add(1'b1, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            drive(0, tbl[i].l, tbl[i].v, tbl[i].s, tbl[i].p);
            step(1);
            check_all($sformatf("vec%0d", i), 0, tbl[i].c, tbl[i].r, tbl[i].d, tbl[i].e);
        end

        // Pause with prescaler at 2, hold 10 cycles, resume
        drive(0, 1'b1, 8'd5, 1'b0, 1'b0); step(1);
        check_all("pz_load", 0, 8'd5, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0); step(1);
        drive(0, 1'b0, 8'd0, 1'b0, 1'b0); step(2);
        drive(0, 1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_all($sformatf("pz_hold%0d", i), 0, 8'd5, 1'b0, 1'b0, 1'b0);
        end
        drive(0, 1'b0, 8'd0, 1'b1, 1'b1); step(1);
        check_all("pz_resume", 0, 8'd5, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b0, 1'b0); step(1);
        check("pz_res+1", 32'(cnt[0]), 32'd5);
        step(1);
        check("pz_res+2", 32'(cnt[0]), 32'd4);

        // Load colliding with a tick edge while running
        drive(0, 1'b1, 8'd7, 1'b0, 1'b0); step(1);
        check_all("col_load7", 0, 8'd7, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b0, 1'b0); step(3);
        check("col_pre", 32'(cnt[0]), 32'd7);
        drive(0, 1'b1, 8'd9, 1'b0, 1'b0); step(1);
        check_all("col_load9", 0, 8'd9, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b0, 1'b0); step(3);
        check("col_+3", 32'(cnt[0]), 32'd9);
        step(1);
        check("col_+4", 32'(cnt[0]), 32'd8);
        drive(0, 1'b1, 8'd0, 1'b0, 1'b0); step(1);
        check_all("col_load0", 0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Start with counter 0 from IDLE is ignored
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0); step(1);
        check_all("zero_start", 0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        drive(0, 1'b1, 8'd4, 1'b0, 1'b0); step(1);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0); step(1);
        drive(0, 1'b0, 8'd0, 1'b0, 1'b0); step(2);
        check_all("rst_pre", 0, 8'd4, 1'b1, 1'b0, 1'b0);
        #2 rst[0] = 1'b1;
        #1 check_all("rst_async", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        step(2);
        rst[0] = 1'b0;
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0); step(1);
        check_all("rst_start", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Auto-reload: 2,1,2,1 with a pulse every 8 edges
        drive(1, 1'b1, 8'd2, 1'b0, 1'b0); step(1);
        drive(1, 1'b0, 8'd0, 1'b1, 1'b0); step(1);
        drive(1, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            step(1);
            exp_c = (((k / 4) % 2) == 0) ? 8'd2 : 8'd1;
            check_all($sformatf("ar_k%0d", k), 1, exp_c, 1'b1, 1'b0, ((k % 8) == 0));
        end

        // Full range: 255 with DIV 2 expires exactly 510 edges after start
        drive(2, 1'b1, 8'd255, 1'b0, 1'b0); step(1);
        drive(2, 1'b0, 8'd0, 1'b1, 1'b0); step(1);
        drive(2, 1'b0, 8'd0, 1'b0, 1'b0);
        found = 0;
        for (int k = 1; k <= 600; k++) begin
            step(1);
            if (k == 2) check("full_k2", 32'(cnt[2]), 32'd254);
            if (ep[2] === 1'b1) begin
                found = k;
                break;
            end
        end
        check("full_expiry_edge", 32'(found), 32'd510);
        check_all("full_end", 2, 8'd0, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
